// File: rtl/interp_commutator.sv
// -----------------------------------------------------------------------------
// interp_commutator
//   Output commutator of a 2-phase polyphase interpolator. Each accepted pair
//   (E1, E2) of branch outputs is gain-normalised (round half up, arithmetic
//   right shift), saturated to OUT_W bits and emitted as two consecutive
//   samples: E1 first (out_phase = 0), then E2 (out_phase = 1). Valid/ready
//   handshakes on both sides; a new pair can be taken in the same cycle the
//   E2 sample leaves, so continuous flow gives one output per clock.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : pair present on in_e1/in_e2
//   in_e1      : signed phase-0 branch sample (IN_W)
//   in_e2      : signed phase-1 branch sample (IN_W)
//   in_ready   : pair is accepted this cycle when in_valid is also high
//   out_valid  : out_data holds a sample
//   out_ready  : downstream takes out_data this cycle
//   out_data   : signed interpolated sample (OUT_W), registered
//   out_phase  : 0 = sample from E1, 1 = from E2, registered
//   sat_cnt    : saturating count of clipped samples
// -----------------------------------------------------------------------------
module interp_commutator #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 11,
  parameter int SHIFT = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_e1,
  input  logic signed [IN_W-1:0]  in_e2,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_phase,
  output logic [15:0]             sat_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    S_E1  = 2'd1,
    S_E2  = 2'd2
  } state_t;

  // One guard bit so adding the rounding constant can never overflow.
  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] MAX_C   = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MIN_C   = SUM_W'(-(64'sd1 <<< (OUT_W - 1)));

  // Round half up, normalise, saturate. Result is {clip_flag, value}.
  function automatic logic [OUT_W:0] scale_sat(input logic signed [IN_W-1:0] x);
    logic signed [SUM_W-1:0] sum_v;
    logic signed [SUM_W-1:0] y_v;
    logic [OUT_W:0]          res_v;
    sum_v = $signed({x[IN_W-1], x}) + ROUND_C;
    y_v   = sum_v >>> SHIFT;
    if (y_v > MAX_C) begin
      res_v = {1'b1, MAX_C[OUT_W-1:0]};
    end else if (y_v < MIN_C) begin
      res_v = {1'b1, MIN_C[OUT_W-1:0]};
    end else begin
      res_v = {1'b0, y_v[OUT_W-1:0]};
    end
    return res_v;
  endfunction

  // Add 0..2 clip events, sticking at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum_v;
    logic [15:0] res_v;
    sum_v = {1'b0, cnt} + {15'd0, inc};
    if (sum_v[16]) begin
      res_v = 16'hFFFF;
    end else begin
      res_v = sum_v[15:0];
    end
    return res_v;
  endfunction

  state_t                   state_q, state_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_phase_q, out_phase_d;
  logic signed [OUT_W-1:0]  hold_q, hold_d;
  logic [15:0]              sat_cnt_q, sat_cnt_d;

  logic [OUT_W:0]           e1_sc;
  logic [OUT_W:0]           e2_sc;
  logic [1:0]               clip_inc;

  assign e1_sc    = scale_sat(in_e1);
  assign e2_sc    = scale_sat(in_e2);
  assign clip_inc = {1'b0, e1_sc[OUT_W]} + {1'b0, e2_sc[OUT_W]};

  // Next-state, datapath loads and the combinational in_ready.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_phase_d = out_phase_q;
    hold_d      = hold_q;
    sat_cnt_d   = sat_cnt_q;
    in_ready    = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d     = S_E1;
          out_data_d  = e1_sc[OUT_W-1:0];
          out_phase_d = 1'b0;
          hold_d      = e2_sc[OUT_W-1:0];
          sat_cnt_d   = sat_add(sat_cnt_q, clip_inc);
        end else begin
          state_d = EMPTY;
        end
      end
      S_E1: begin
        in_ready = 1'b0;
        if (out_ready) begin
          state_d     = S_E2;
          out_data_d  = hold_q;
          out_phase_d = 1'b1;
        end else begin
          state_d = S_E1;
        end
      end
      S_E2: begin
        // The E2 slot frees up as it leaves, so a new pair can enter at once.
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          state_d     = S_E1;
          out_data_d  = e1_sc[OUT_W-1:0];
          out_phase_d = 1'b0;
          hold_d      = e2_sc[OUT_W-1:0];
          sat_cnt_d   = sat_add(sat_cnt_q, clip_inc);
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = S_E2;
        end
      end
      default: begin
        in_ready = 1'b0;
        state_d  = EMPTY;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_phase_q <= 1'b0;
      hold_q      <= '0;
      sat_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_phase_q <= out_phase_d;
      hold_q      <= hold_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign out_valid = (state_q == S_E1) || (state_q == S_E2);
  assign out_data  = out_data_q;
  assign out_phase = out_phase_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_interp_commutator.sv
// -----------------------------------------------------------------------------
// tb_interp_commutator
//   Directed self-checking bench for interp_commutator (default parameters:
//   IN_W = 20, OUT_W = 11, SHIFT = 9).
// -----------------------------------------------------------------------------
module tb_interp_commutator;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [19:0] in_e1;
  logic signed [19:0] in_e2;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic signed [10:0] out_data;
  logic               out_phase;
  logic [15:0]        sat_cnt;

  int checks;
  int errors;

  interp_commutator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_e1     (in_e1),
    .in_e2     (in_e2),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_phase (out_phase),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single pair from EMPTY with out_ready held high.
  task automatic send_pair(input int e1, input int e2, input int y1, input int y2,
                           input string tag);
    in_e1     = 20'(e1);
    in_e2     = 20'(e2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_v1"}, out_valid, 1);
    check({tag, "_d1"}, out_data, y1);
    check({tag, "_p1"}, out_phase, 0);
    step();
    check({tag, "_v2"}, out_valid, 1);
    check({tag, "_d2"}, out_data, y2);
    check({tag, "_p2"}, out_phase, 1);
    step();
    check({tag, "_v3"}, out_valid, 0);
  endtask

  initial begin
    int q[$];
    int y1, y2, r1, r2;
    int out_cnt, acc_cnt, cyc, exp_v;
    logic new_pair, prev_stall, prev_phase;
    logic signed [10:0] prev_data;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_e1     = 20'sd0;
    in_e2     = 20'sd0;
    out_ready = 1'b0;

    // Reset state, held across clock edges
    in_valid = 1'b1;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_phase", out_phase, 0);
    check("rst_sat", sat_cnt, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    check("rst_rel_ready", in_ready, 1);

    // Basic pair: 51200 -> 100, -51200 -> -100
    send_pair(51200, -51200, 100, -100, "basic");
    // Rounding boundaries
    send_pair(256, 255, 1, 0, "rnd_pos");
    send_pair(-256, -257, 0, -1, "rnd_neg");
    check("rnd_sat", sat_cnt, 0);
    // Saturation: only the positive extreme clips
    send_pair(524287, -524288, 1023, -1024, "sat_ext");
    check("sat_one", sat_cnt, 1);

    // Streaming 8 pairs, continuous valid/ready
    in_e1     = 20'sd512;
    in_e2     = -20'sd512;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("strm_ready0", in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      step();
      exp_v = (i % 2 == 0) ? (i / 2 + 1) : -(i / 2 + 1);
      check("strm_valid", out_valid, 1);
      check("strm_phase", out_phase, i % 2);
      check("strm_data", out_data, exp_v);
      check("strm_ready", in_ready, i % 2);
      if (i % 2 == 1) begin
        if (i / 2 + 1 == 8) begin
          in_valid = 1'b0;
        end else begin
          in_e1 = 20'((i / 2 + 2) * 512);
          in_e2 = 20'(-(i / 2 + 2) * 512);
        end
      end
    end
    step();
    check("strm_end", out_valid, 0);

    // Random stalls over 1000 pairs against an ordered reference queue
    out_cnt    = 0;
    acc_cnt    = 0;
    cyc        = 0;
    new_pair   = 1'b1;
    prev_stall = 1'b0;
    prev_phase = 1'b0;
    prev_data  = 11'sd0;
    y1 = 0; y2 = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_phase", out_phase, prev_phase);
      end
      if (new_pair) begin
        y1 = int'($urandom_range(2046)) - 1023;
        y2 = int'($urandom_range(2046)) - 1023;
        r1 = int'($urandom_range(511)) - 256;
        r2 = int'($urandom_range(511)) - 256;
        in_e1 = 20'(y1 * 512 + r1);
        in_e2 = 20'(y2 * 512 + r2);
        new_pair = 1'b0;
      end
      out_ready = ($urandom_range(1) == 1);
      in_valid  = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_extra", q.size(), 1);
        end else begin
          check("rand_data", out_data, q.pop_front());
          check("rand_phase", out_phase, out_cnt % 2);
        end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back(y1);
        q.push_back(y2);
        acc_cnt++;
        new_pair = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_phase = out_phase;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rand_accepts", acc_cnt, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("drain_extra", q.size(), 1);
        end else begin
          check("drain_data", out_data, q.pop_front());
          check("drain_phase", out_phase, out_cnt % 2);
        end
        out_cnt++;
      end
      step();
    end
    check("rand_outputs", out_cnt, 2000);
    check("rand_left", q.size(), 0);
    check("rand_idle", out_valid, 0);
    check("rand_sat", sat_cnt, 1);

    // Clear the counter, then drive 65536+ clip events
    rst = 1'b1;
    #2;
    check("srst_sat", sat_cnt, 0);
    rst = 1'b0;
    step();
    in_e1     = 20'sd524287;
    in_e2     = 20'sd524287;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    // Pairs accepted on edges 1,3,5,...: 65533 edges -> 32767 pairs
    repeat (65533) step();
    in_valid = 1'b0;
    step();
    step();
    check("sat_65534", sat_cnt, 65534);
    send_pair(524287, 0, 1023, 0, "sat_top");
    check("sat_65535", sat_cnt, 65535);
    send_pair(524287, 524287, 1023, 1023, "sat_hold");
    check("sat_nowrap", sat_cnt, 65535);

    // Reset while stalled in S_E1
    in_e1     = 20'sd1024;
    in_e2     = 20'sd1536;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("mid_valid", out_valid, 1);
    check("mid_data", out_data, 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sat", sat_cnt, 0);
    check("mid_rst_data", out_data, 0);
    step();
    rst = 1'b0;
    check("post_rst_ready", in_ready, 1);
    step();
    check("post_rst_valid", out_valid, 0);
    send_pair(5 * 512, -7 * 512, 5, -7, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interp_commutator.md
INTERP_COMMUTATOR -- requirements
Module: interp_commutator

Interface
REQ-001 SHALL have parameter IN_W, default 20, polyphase branch sample width (signed).
REQ-002 SHALL have parameter OUT_W, default 11, interpolated output width (signed).
REQ-003 SHALL have parameter SHIFT, default 9, gain-normalisation right shift (per-phase coefficient sum 512).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  branch pair present on in_e1/in_e2.
REQ-007 SHALL have port in_e1  input  IN_W  signed phase-0 branch output (E1 comb).
REQ-008 SHALL have port in_e2  input  IN_W  signed phase-1 branch output (E2 comb).
REQ-009 SHALL have port in_ready  output  1  block accepts pair this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data holds a sample.
REQ-011 SHALL have port out_ready  input  1  downstream takes out_data this cycle.
REQ-012 SHALL have port out_data  output  OUT_W  signed interpolated sample, registered.
REQ-013 SHALL have port out_phase  output  1  0 = sample from E1, 1 = from E2, registered.
REQ-014 SHALL have port sat_cnt  output  16  saturating count of clipped samples.

Function
REQ-015 SHALL accept a pair when in_valid && in_ready, and transfer a sample when out_valid && out_ready.
REQ-016 SHALL scale each branch value x as y = (x + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up), computed at acceptance.
REQ-017 SHALL saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any clip SHALL count as one saturation event.
REQ-018 SHALL use FSM states EMPTY, S_E1, S_E2; out_valid = 1 in S_E1/S_E2, 0 in EMPTY.
REQ-019 SHALL drive in_ready = 1 in EMPTY, 0 in S_E1, out_ready in S_E2 (combinational).
REQ-020 SHALL, on accept in EMPTY: next cycle state S_E1, out_data = scaled E1, out_phase = 0, hold register = scaled E2.
REQ-021 SHALL, in S_E1 with out_ready: next cycle state S_E2, out_data = hold, out_phase = 1; without out_ready: all outputs held stable.
REQ-022 SHALL, in S_E2 with out_ready and in_valid: accept new pair, next cycle S_E1 with new scaled E1 (no bubble).
REQ-023 SHALL, in S_E2 with out_ready and no in_valid: next cycle EMPTY; without out_ready: outputs held stable, no accept.
REQ-024 SHALL sustain one output per cycle and one input pair per two cycles under continuous in_valid/out_ready.
REQ-025 SHALL emit samples strictly in order E1(n), E2(n), E1(n+1), ...; no sample dropped or duplicated under any backpressure pattern.
REQ-026 SHALL increment sat_cnt at acceptance by 0, 1 or 2 (clips in the pair), stopping at 16'hFFFF (no wrap).
REQ-027 SHALL keep out_data and out_phase unchanged while out_valid && !out_ready.

Reset
REQ-028 SHALL, while rst = 1, force state EMPTY, out_valid 0, out_data 0, out_phase 0, hold 0, sat_cnt 0, regardless of clk.
REQ-029 SHALL, on rst asserted mid-operation, discard pending E1/E2 samples; first accepted pair after release starts at E1.
REQ-030 SHALL present in_ready = 1 on the first cycle after reset release.

Verification
REQ-031 Single pair e1 = 51200, e2 = -51200, out_ready = 1 -> out_data 100 (phase 0) then -100 (phase 1), then out_valid = 0.
REQ-032 Rounding: e1 = 256, e2 = 255 -> 1 then 0; e1 = -256, e2 = -257 -> 0 then -1; sat_cnt stays 0.
REQ-033 Saturation: e1 = 524287, e2 = -524288 -> 1023 then -1024, sat_cnt = 1; 65536 clip events -> sat_cnt = 65535.
REQ-034 Streaming 8 pairs with continuous valid/ready -> 16 consecutive out_valid cycles, alternating phase, in_ready pattern 1,0,1,0....
REQ-035 Random out_ready stalls (~50%) over 1000 pairs -> output sequence equals reference model, no loss/duplication, data stable during stalls.
REQ-036 rst pulsed while in S_E1 with out_ready = 0 -> next cycle out_valid = 0, sat_cnt = 0; next pair outputs its E1 first.
